// File: rtl/mult_iter.sv
// Iterative 32x32 multiplier for the MIPS HI/LO path; retires STEP_BITS multiplier
// bits per cycle behind a start/busy/done handshake, with cancel and synchronous reset.
module mult_iter #(
  parameter int STEP_BITS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic [5:0]  i_instr_func,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_mult_hi,
  output logic [31:0] o_mult_lo,
  output logic [5:0]  o_instr_func
);

  localparam int         N          = 32 / STEP_BITS;
  localparam logic [5:0] LP_LAST    = 6'(N - 1);
  localparam logic [5:0] LP_STEP    = 6'(STEP_BITS);
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MADD  = 6'b000000;
  localparam logic [5:0] FUNC_MSUB  = 6'b000100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [5:0]  r_count;
  logic        r_neg;
  logic [5:0]  r_func;

  logic        w_is_signed;
  logic        w_accept;
  logic [5:0]  w_shift;
  logic [63:0] w_partial;
  logic [63:0] w_addend;
  logic [63:0] w_acc_neg;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Operand decode, acceptance and the per-step partial product.
  always_comb begin
    w_is_signed = (i_instr_func == FUNC_MULT) || (i_instr_func == FUNC_MADD) ||
                  (i_instr_func == FUNC_MSUB);
    w_accept    = i_start && !i_cancel && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_shift     = r_count * LP_STEP;
    w_partial   = {32'd0, r_mcand} * {{(64 - STEP_BITS){1'b0}}, r_mplier[STEP_BITS-1:0]};
    w_addend    = w_partial << w_shift;
    w_acc_neg   = ~r_acc + 64'd1;
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_mcand      <= 32'd0;
      r_mplier     <= 32'd0;
      r_acc        <= 64'd0;
      r_count      <= 6'd0;
      r_neg        <= 1'b0;
      r_func       <= 6'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_mult_hi    <= 32'd0;
      o_mult_lo    <= 32'd0;
      o_instr_func <= 6'd0;
    end else if (i_cancel) begin
      r_state <= S_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else if (w_accept) begin
      r_state  <= S_CALC;
      r_mcand  <= f_mag(i_rs, w_is_signed);
      r_mplier <= f_mag(i_rt, w_is_signed);
      r_neg    <= w_is_signed && (i_rs[31] ^ i_rt[31]);
      r_func   <= i_instr_func;
      r_acc    <= 64'd0;
      r_count  <= 6'd0;
      o_busy   <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        S_CALC: begin
          r_acc    <= r_acc + w_addend;
          r_mplier <= r_mplier >> STEP_BITS;
          r_count  <= r_count + 6'd1;
          o_busy   <= 1'b1;
          o_done   <= 1'b0;
          if (r_count == LP_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          if (r_neg) begin
            {o_mult_hi, o_mult_lo} <= w_acc_neg;
          end else begin
            {o_mult_hi, o_mult_lo} <= r_acc;
          end
          o_instr_func <= r_func;
          r_state      <= S_DONE;
          o_busy       <= 1'b0;
          o_done       <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// Self-checking bench for mult_iter: three instances (STEP_BITS 1, 2, 4) driven by
// directed and random operations, compared against a plain-arithmetic product model.
module tb_mult_iter;

  localparam logic [5:0] FUNC_MADD  = 6'b000000;
  localparam logic [5:0] FUNC_MADDU = 6'b000001;
  localparam logic [5:0] FUNC_MSUB  = 6'b000100;
  localparam logic [5:0] FUNC_MSUBU = 6'b000101;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;

  logic        clk;
  logic        rst    [3];
  logic        start  [3];
  logic        cancel [3];
  logic [5:0]  func   [3];
  logic [31:0] rs     [3];
  logic [31:0] rt     [3];
  logic        busy   [3];
  logic        done   [3];
  logic [31:0] hi     [3];
  logic [31:0] lo     [3];
  logic [5:0]  ofunc  [3];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mult_iter #(.STEP_BITS(1 << g)) u_dut (
      .i_clk(clk), .i_rst(rst[g]), .i_start(start[g]), .i_cancel(cancel[g]),
      .i_instr_func(func[g]), .i_rs(rs[g]), .i_rt(rt[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_mult_hi(hi[g]), .o_mult_lo(lo[g]),
      .o_instr_func(ofunc[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int k);
    return 32 / (1 << k);
  endfunction

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (f == FUNC_MULT || f == FUNC_MADD || f == FUNC_MSUB) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int k, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    func[k] = f; rs[k] = a; rt[k] = b; start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check($sformatf("busy_after_accept[%0d]", k), {63'd0, busy[k]}, 64'd1);
    check($sformatf("no_done_after_accept[%0d]", k), {63'd0, done[k]}, 64'd0);
  endtask

  task automatic wait_done(input int k, input int elapsed, input logic [5:0] f, input logic [63:0] exp);
    int cnt;
    bit overlap;
    cnt = elapsed;
    overlap = 1'b0;
    while (done[k] !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
      if (busy[k] === 1'b1 && done[k] === 1'b1) overlap = 1'b1;
    end
    check($sformatf("latency[%0d]", k), 64'(cnt), 64'(n_of(k) + 1));
    check($sformatf("busy_done_overlap[%0d]", k), {63'd0, overlap}, 64'd0);
    check($sformatf("product[%0d]", k), {hi[k], lo[k]}, exp);
    check($sformatf("func[%0d]", k), {58'd0, ofunc[k]}, {58'd0, f});
  endtask

  task automatic run_op(input int k, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    launch(k, f, a, b);
    wait_done(k, 0, f, model(f, a, b));
  endtask

  // Watches k for cycles cycles; flags any done pulse or output change.
  task automatic quiet(input int k, input int cycles, input logic [63:0] exp, input string tag);
    bit seen;
    bit moved;
    seen = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done[k] !== 1'b0) seen = 1'b1;
      if ({hi[k], lo[k]} !== exp) moved = 1'b1;
    end
    check({tag, "_no_done"}, {63'd0, seen}, 64'd0);
    check({tag, "_hold"}, {63'd0, moved}, 64'd0);
  endtask

  initial begin
    logic [5:0]  flist [6];
    logic [5:0]  f;
    logic [31:0] a, b;
    int          k;
    flist = '{FUNC_MULT, FUNC_MULTU, FUNC_MADD, FUNC_MADDU, FUNC_MSUB, FUNC_MSUBU};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b1; cancel[i] = 1'b0;
      func[i] = FUNC_MULT; rs[i] = 32'd5; rt[i] = 32'd5;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy[%0d]", i), {63'd0, busy[i]}, 64'd0);
      check($sformatf("rst_done[%0d]", i), {63'd0, done[i]}, 64'd0);
      check($sformatf("rst_prod[%0d]", i), {hi[i], lo[i]}, 64'd0);
      check($sformatf("rst_func[%0d]", i), {58'd0, ofunc[i]}, 64'd0);
    end

    // Basic latency and the listed corner products on STEP_BITS=2.
    run_op(1, FUNC_MULT, 32'd7, 32'd6);
    check("mult_7x6_const", {hi[1], lo[1]}, 64'h0000_0000_0000_002A);
    tick();
    check("done_one_cycle", {63'd0, done[1]}, 64'd0);
    run_op(1, FUNC_MULT, 32'hFFFF_FFFF, 32'h0000_0001);
    check("mult_neg1_const", {hi[1], lo[1]}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(1, FUNC_MSUB, 32'h8000_0000, 32'h8000_0000);
    check("msub_min_const", {hi[1], lo[1]}, 64'h4000_0000_0000_0000);
    run_op(1, FUNC_MADD, 32'h8000_0000, 32'h0000_0001);
    check("madd_min_const", {hi[1], lo[1]}, 64'hFFFF_FFFF_8000_0000);
    run_op(1, FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_const", {hi[1], lo[1]}, 64'hFFFF_FFFE_0000_0001);
    run_op(1, FUNC_MADDU, 32'h0001_0000, 32'h0001_0000);
    check("maddu_const", {hi[1], lo[1]}, 64'h0000_0001_0000_0000);

    // Random operations across all step widths.
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(2, 0));
      f = flist[$urandom_range(5, 0)];
      a = $urandom;
      b = $urandom;
      if ((i % 6) == 0) a = 32'h8000_0000;
      if ((i % 7) == 0) b = 32'hFFFF_FFFF;
      run_op(k, f, a, b);
    end

    // Start while busy is ignored.
    tick();
    launch(1, FUNC_MULTU, 32'd1234, 32'd5678);
    tick();
    func[1] = FUNC_MULT; rs[1] = 32'hDEAD_BEEF; rt[1] = 32'h0BAD_F00D; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_done(1, 2, FUNC_MULTU, 64'd7006652);

    // Back-to-back: start accepted in the DONE cycle.
    launch(1, FUNC_MSUBU, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(1, 0, FUNC_MSUBU, model(FUNC_MSUBU, 32'h1234_5678, 32'h9ABC_DEF0));

    // Cancel mid-operation, then cancel colliding with start in IDLE.
    run_op(1, FUNC_MULTU, 32'd3, 32'd5);
    tick();
    launch(1, FUNC_MULTU, 32'd9, 32'd9);
    for (int i = 0; i < 4; i++) tick();
    cancel[1] = 1'b1;
    tick();
    cancel[1] = 1'b0;
    check("cancel_busy", {63'd0, busy[1]}, 64'd0);
    check("cancel_done", {63'd0, done[1]}, 64'd0);
    check("cancel_prod", {hi[1], lo[1]}, 64'h0000_0000_0000_000F);
    quiet(1, 25, 64'h0000_0000_0000_000F, "cancel");
    func[1] = FUNC_MULTU; rs[1] = 32'd100; rt[1] = 32'd100; start[1] = 1'b1; cancel[1] = 1'b1;
    tick();
    start[1] = 1'b0; cancel[1] = 1'b0;
    check("cancel_start_busy", {63'd0, busy[1]}, 64'd0);
    quiet(1, 25, 64'h0000_0000_0000_000F, "cancel_start");
    run_op(1, FUNC_MULTU, 32'd4, 32'd4);

    // Reset mid-operation on every step width, then a normal operation.
    for (int j = 0; j < 3; j++) begin
      tick();
      launch(j, FUNC_MULT, 32'hFFFF_FFF0, 32'd77);
      for (int i = 0; i < 7; i++) tick();
      rst[j] = 1'b1;
      tick();
      rst[j] = 1'b0;
      check($sformatf("mid_rst_busy[%0d]", j), {63'd0, busy[j]}, 64'd0);
      check($sformatf("mid_rst_done[%0d]", j), {63'd0, done[j]}, 64'd0);
      check($sformatf("mid_rst_prod[%0d]", j), {hi[j], lo[j]}, 64'd0);
      check($sformatf("mid_rst_func[%0d]", j), {58'd0, ofunc[j]}, 64'd0);
      quiet(j, 40, 64'd0, $sformatf("mid_rst[%0d]", j));
      run_op(j, FUNC_MULTU, 32'd2, 32'd3);
      check($sformatf("post_rst_const[%0d]", j), {hi[j], lo[j]}, 64'd6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
